writeback_regfile: RTL and testbench
====================================

Name: writeback_regfile

Overview:
- Final pipeline stage. Consumes the execute stage's 3a result bundle and commits it to the architectural state.
- Architectural state held here: 16x32 register file, CPSR and SPSR.
- Registers the result into a 4a writeback latch, commits it one cycle later and bypasses in-flight results to the decode-stage read ports.
- A write to r15 is not stored. It becomes a registered branch redirect back to fetch.

Parameters:
- CPSR_RESET, 32'h000000D3, CPSR value after reset (SVC mode, I=F=1).
- PC_OFFSET, 32'h8, added to the reader's pc when r15 is read.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous reset, active-high
- stall_3a  in  1  hold 4a latch; no capture this cycle
- bubble_3a  in  1  3a slot carries no instruction
- write_reg_3a  in  1  3a result writes a register
- write_num_3a  in  4  destination register
- write_data_3a  in  32  destination data
- cpsrup_3a  in  1  3a carries PSR update
- cpsr_3a  in  32  new CPSR
- spsr_3a  in  32  new SPSR
- rd_pc_1a  in  32  pc of the instruction reading operands
- rd_num0_1a, rd_num1_1a, rd_num2_1a  in  4 each  read addresses
- rd_data0_1a, rd_data1_1a, rd_data2_1a  out  32 each  read data (combinational)
- cpsr  out  32  current CPSR, including bypass
- spsr  out  32  current SPSR, including bypass
- jmp_4a  out  1  redirect valid, one-cycle pulse
- jmppc_4a  out  32  redirect target

Behaviour:
- Capture into the 4a latch, on each clk with !stall_3a:
  - valid_4a <= !bubble_3a
  - wr_4a <= write_reg_3a & !bubble_3a
  - num/data/cpsrup/cpsr/spsr copied from the 3a inputs
- When stall_3a=1:
  - latch holds its contents
  - valid_4a is forced to 0 after one commit, so a held entry commits exactly once
- Commit, every cycle valid_4a=1:
  - If wr_4a and num!=15: regs[num] <= data.
  - If cpsrup_4a: CPSR <= cpsr_4a and SPSR <= spsr_4a.
  - Commit latency: 2 clk edges from 3a presentation to architectural state.
- r15 write (wr_4a, num=15):
  - regs unchanged
  - jmp_4a=1 and jmppc_4a=data_4a for the cycle valid_4a is high
  - jmp_4a is 0 otherwise
- Reads:
  - rd_num=15 returns rd_pc_1a+PC_OFFSET (32-bit wrap). It is never bypassed.
  - Otherwise priority: 3a result (if !bubble_3a & write_reg_3a & num match) > 4a latch (if valid & wr & match) > regs.
- cpsr/spsr outputs use the same priority: 3a if !bubble_3a & cpsrup_3a, else 4a if valid & cpsrup, else stored value.
- Simultaneous commit and read of the same register: the bypass returns the committing data.
- Reset, rst=1 on a clk edge:
  - all regs=0, CPSR=CPSR_RESET, SPSR=0
  - valid_4a=0, wr_4a=0, jmp_4a=0, jmppc_4a=0
  - Reset overrides stall and any pending commit. A latched but uncommitted result is discarded.
- No X propagation: unused latch fields are don't-care, but their valid qualifiers are always 0 or 1.

Test Plan:
- Reset then idle: rd_num0=3 -> 0. cpsr=32'h000000D3. jmp_4a=0 for 10 cycles.
- Write r4=32'hDEADBEEF (bubble=0):
  - same cycle, read r4 -> DEADBEEF (3a bypass)
  - next cycle -> DEADBEEF (4a bypass)
  - cycle after -> DEADBEEF (regs)
- Bubble_3a=1 with write_reg_3a=1, r5=32'h1234: r5 stays 0 on all reads; no commit.
- Write r15=32'h00001000 -> jmp_4a=1 for exactly one cycle, jmppc_4a=32'h1000. Read r15 with rd_pc_1a=32'h200 -> 32'h208.
- stall_3a=1 for 3 cycles while 3a presents r6=7:
  - r6 not captured until the stall drops
  - an earlier latched r2=9 commits once
  - jmp_4a does not repeat for a held r15 write
- cpsrup_3a with cpsr_3a=32'h600000D3, then rst asserted while it sits in the 4a latch -> cpsr reads 32'h000000D3; the update is lost.

Source files
------------

// File: rtl/writeback_regfile_if.sv
// Writeback stage bus: the execute-stage (3a) result bundle, the decode-stage
// read ports, the PSR outputs and the branch redirect back to fetch.
interface writeback_regfile_if;
    // 3a result bundle
    logic        stall_3a;
    logic        bubble_3a;
    logic        write_reg_3a;
    logic [3:0]  write_num_3a;
    logic [31:0] write_data_3a;
    logic        cpsrup_3a;
    logic [31:0] cpsr_3a;
    logic [31:0] spsr_3a;
    // decode-stage operand reads
    logic [31:0] rd_pc_1a;
    logic [3:0]  rd_num0_1a;
    logic [3:0]  rd_num1_1a;
    logic [3:0]  rd_num2_1a;
    logic [31:0] rd_data0_1a;
    logic [31:0] rd_data1_1a;
    logic [31:0] rd_data2_1a;
    // architectural PSRs (bypassed) and redirect
    logic [31:0] cpsr;
    logic [31:0] spsr;
    logic        jmp_4a;
    logic [31:0] jmppc_4a;

    modport master (
        output stall_3a, bubble_3a, write_reg_3a, write_num_3a, write_data_3a,
               cpsrup_3a, cpsr_3a, spsr_3a, rd_pc_1a,
               rd_num0_1a, rd_num1_1a, rd_num2_1a,
        input  rd_data0_1a, rd_data1_1a, rd_data2_1a, cpsr, spsr, jmp_4a, jmppc_4a
    );

    modport slave (
        input  stall_3a, bubble_3a, write_reg_3a, write_num_3a, write_data_3a,
               cpsrup_3a, cpsr_3a, spsr_3a, rd_pc_1a,
               rd_num0_1a, rd_num1_1a, rd_num2_1a,
        output rd_data0_1a, rd_data1_1a, rd_data2_1a, cpsr, spsr, jmp_4a, jmppc_4a
    );
endinterface

// File: rtl/writeback_regfile.sv
// Writeback stage: latches the 3a result into the 4a slot, commits it to the
// 16x32 register file / CPSR / SPSR one cycle later, bypasses in-flight results
// to the three decode read ports, and turns r15 writes into a fetch redirect.
module writeback_regfile #(
    parameter logic [31:0] CPSR_RESET = 32'h000000D3,
    parameter logic [31:0] PC_OFFSET  = 32'h00000008
) (
    input logic          clk,
    input logic          rst,
    writeback_regfile_if.slave wb
);

    // 4a writeback latch
    logic        valid_4a_q,  valid_4a_d;
    logic        wr_4a_q,     wr_4a_d;
    logic [3:0]  num_4a_q,    num_4a_d;
    logic [31:0] data_4a_q,   data_4a_d;
    logic        cpsrup_4a_q, cpsrup_4a_d;
    logic [31:0] cpsr_4a_q,   cpsr_4a_d;
    logic [31:0] spsr_4a_q,   spsr_4a_d;

    // architectural state
    logic [31:0] regs_q [16];
    logic [31:0] cpsr_q;
    logic [31:0] spsr_q;

    // qualified hit terms shared by the bypass network and the commit logic
    logic hit3a_reg, hit3a_psr, hit4a_reg, hit4a_psr;
    logic commit_reg;

    assign hit3a_reg  = !wb.bubble_3a && wb.write_reg_3a;
    assign hit3a_psr  = !wb.bubble_3a && wb.cpsrup_3a;
    assign hit4a_reg  = valid_4a_q && wr_4a_q;
    assign hit4a_psr  = valid_4a_q && cpsrup_4a_q;
    assign commit_reg = hit4a_reg && (num_4a_q != 4'd15);

    // Latch next state: capture when not stalled; a stall holds the fields but
    // drops valid so a held entry is committed only once.
    always_comb begin
        valid_4a_d  = 1'b0;
        wr_4a_d     = wr_4a_q;
        num_4a_d    = num_4a_q;
        data_4a_d   = data_4a_q;
        cpsrup_4a_d = cpsrup_4a_q;
        cpsr_4a_d   = cpsr_4a_q;
        spsr_4a_d   = spsr_4a_q;
        if (!wb.stall_3a) begin
            valid_4a_d  = !wb.bubble_3a;
            wr_4a_d     = wb.write_reg_3a && !wb.bubble_3a;
            num_4a_d    = wb.write_num_3a;
            data_4a_d   = wb.write_data_3a;
            cpsrup_4a_d = wb.cpsrup_3a;
            cpsr_4a_d   = wb.cpsr_3a;
            spsr_4a_d   = wb.spsr_3a;
        end
    end

    // 4a latch register; reset discards any uncommitted result.
    always_ff @(posedge clk) begin
        if (rst) begin
            valid_4a_q  <= 1'b0;
            wr_4a_q     <= 1'b0;
            num_4a_q    <= 4'd0;
            data_4a_q   <= 32'd0;
            cpsrup_4a_q <= 1'b0;
            cpsr_4a_q   <= 32'd0;
            spsr_4a_q   <= 32'd0;
        end else begin
            valid_4a_q  <= valid_4a_d;
            wr_4a_q     <= wr_4a_d;
            num_4a_q    <= num_4a_d;
            data_4a_q   <= data_4a_d;
            cpsrup_4a_q <= cpsrup_4a_d;
            cpsr_4a_q   <= cpsr_4a_d;
            spsr_4a_q   <= spsr_4a_d;
        end
    end

    // Register file commit; r15 is never stored (it becomes a redirect).
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 16; i++) begin
                regs_q[i] <= 32'd0;
            end
        end else if (commit_reg) begin
            regs_q[num_4a_q] <= data_4a_q;
        end
    end

    // PSR commit.
    always_ff @(posedge clk) begin
        if (rst) begin
            cpsr_q <= CPSR_RESET;
            spsr_q <= 32'd0;
        end else if (hit4a_psr) begin
            cpsr_q <= cpsr_4a_q;
            spsr_q <= spsr_4a_q;
        end
    end

    // Read ports: r15 yields pc+offset, else youngest in-flight result wins.
    logic [2:0][3:0]  rd_num_w;
    logic [2:0][31:0] rd_data_w;

    assign rd_num_w[0] = wb.rd_num0_1a;
    assign rd_num_w[1] = wb.rd_num1_1a;
    assign rd_num_w[2] = wb.rd_num2_1a;

    generate
        for (genvar gi = 0; gi < 3; gi++) begin : g_rd_port
            assign rd_data_w[gi] =
                (rd_num_w[gi] == 4'd15)                           ? wb.rd_pc_1a + PC_OFFSET :
                (hit3a_reg && (wb.write_num_3a == rd_num_w[gi]))  ? wb.write_data_3a :
                (hit4a_reg && (num_4a_q == rd_num_w[gi]))         ? data_4a_q :
                                                                    regs_q[rd_num_w[gi]];
        end
    endgenerate

    assign wb.rd_data0_1a = rd_data_w[0];
    assign wb.rd_data1_1a = rd_data_w[1];
    assign wb.rd_data2_1a = rd_data_w[2];

    assign wb.cpsr = hit3a_psr ? wb.cpsr_3a : (hit4a_psr ? cpsr_4a_q : cpsr_q);
    assign wb.spsr = hit3a_psr ? wb.spsr_3a : (hit4a_psr ? spsr_4a_q : spsr_q);

    // Redirect is driven straight from the latch, so it is high only in the
    // single cycle the r15 entry is valid.
    assign wb.jmp_4a   = hit4a_reg && (num_4a_q == 4'd15);
    assign wb.jmppc_4a = data_4a_q;

endmodule

// File: tb/tb_writeback_regfile.sv
// Bench for writeback_regfile: a reset/idle sequence, a cycle-by-cycle vector
// table for the bypass, bubble, r15, stall and reset corners, then random
// traffic checked against an architectural model.
module tb_writeback_regfile;

    logic clk;
    logic rst;
    int   n_checks;
    int   n_fail;

    writeback_regfile_if bus ();

    writeback_regfile dut (
        .clk (clk),
        .rst (rst),
        .wb  (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        logic        rst;
        logic        stall;
        logic        bub;
        logic        wr;
        logic [3:0]  num;
        logic [31:0] data;
        logic        cu;
        logic [31:0] cpsr_in;
        logic [31:0] spsr_in;
        logic [31:0] pc;
        logic [3:0]  n0;
        logic [3:0]  n1;
        logic [31:0] e0;
        logic [31:0] e1;
        logic [31:0] ecpsr;
        logic [31:0] espsr;
        logic        ejmp;
        logic [31:0] ejpc;
    } vec_t;

    vec_t vecs[$];

    task automatic row(input logic r, input logic st, input logic bub, input logic wr,
                       input logic [3:0] num, input logic [31:0] data, input logic cu,
                       input logic [31:0] cin, input logic [31:0] sin, input logic [31:0] pc,
                       input logic [3:0] n0, input logic [3:0] n1,
                       input logic [31:0] e0, input logic [31:0] e1,
                       input logic [31:0] ecpsr, input logic [31:0] espsr,
                       input logic ejmp, input logic [31:0] ejpc);
        vec_t v;
        v.rst = r; v.stall = st; v.bub = bub; v.wr = wr; v.num = num; v.data = data;
        v.cu = cu; v.cpsr_in = cin; v.spsr_in = sin; v.pc = pc; v.n0 = n0; v.n1 = n1;
        v.e0 = e0; v.e1 = e1; v.ecpsr = ecpsr; v.espsr = espsr; v.ejmp = ejmp; v.ejpc = ejpc;
        vecs.push_back(v);
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic drive(input logic r, input logic st, input logic bub, input logic wr,
                         input logic [3:0] num, input logic [31:0] data, input logic cu,
                         input logic [31:0] cin, input logic [31:0] sin, input logic [31:0] pc,
                         input logic [3:0] n0, input logic [3:0] n1, input logic [3:0] n2);
        rst               = r;
        bus.stall_3a      = st;
        bus.bubble_3a     = bub;
        bus.write_reg_3a  = wr;
        bus.write_num_3a  = num;
        bus.write_data_3a = data;
        bus.cpsrup_3a     = cu;
        bus.cpsr_3a       = cin;
        bus.spsr_3a       = sin;
        bus.rd_pc_1a      = pc;
        bus.rd_num0_1a    = n0;
        bus.rd_num1_1a    = n1;
        bus.rd_num2_1a    = n2;
    endtask

    // architectural reference: state as the program sees it once a result
    // has been accepted into writeback
    logic [31:0] m_regs [16];
    logic [31:0] m_cpsr, m_spsr;
    logic        m_jmp;
    logic [31:0] m_jpc;

    task automatic model_reset();
        for (int i = 0; i < 16; i++) m_regs[i] = 32'd0;
        m_cpsr = 32'h000000D3;
        m_spsr = 32'd0;
        m_jmp  = 1'b0;
        m_jpc  = 32'd0;
    endtask

    function automatic logic [31:0] m_read(input logic [3:0] n);
        if (n == 4'd15) return bus.rd_pc_1a + 32'd8;
        if (!bus.bubble_3a && bus.write_reg_3a && bus.write_num_3a == n) return bus.write_data_3a;
        return m_regs[n];
    endfunction

    initial begin
        n_checks = 0;
        n_fail   = 0;

        // reset, then ten idle cycles
        drive(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 3, 0, 0);
        @(posedge clk); @(posedge clk); #1;
        for (int c = 0; c < 10; c++) begin
            drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 3, 0, 0);
            #1;
            chk($sformatf("idle%0d rd0", c), bus.rd_data0_1a, 32'd0);
            chk($sformatf("idle%0d cpsr", c), bus.cpsr, 32'h000000D3);
            chk($sformatf("idle%0d jmp", c), {31'd0, bus.jmp_4a}, 32'd0);
            if (c == 0) begin
                chk("idle spsr", bus.spsr, 32'd0);
                chk("idle jmppc", bus.jmppc_4a, 32'd0);
            end
            $display("idle cycle %0d rd0=%h cpsr=%h jmp=%b", c, bus.rd_data0_1a, bus.cpsr, bus.jmp_4a);
            @(posedge clk); #1;
        end

        //    rst st bub wr num data          cu cpsr_in       spsr pc     n0 n1  e0            e1            ecpsr          espsr ejmp ejpc
        row(0, 0, 0, 0, 0,  0,            0, 0,            0,   0,     3, 0,  0,            0,            32'h000000D3,  0,    0, 0);
        row(0, 0, 0, 1, 4,  32'hDEADBEEF, 0, 0,            0,   0,     4, 5,  32'hDEADBEEF, 0,            32'h000000D3,  0,    0, 0);
        row(0, 0, 0, 0, 0,  0,            0, 0,            0,   0,     4, 5,  32'hDEADBEEF, 0,            32'h000000D3,  0,    0, 0);
        row(0, 0, 0, 0, 0,  0,            0, 0,            0,   0,     4, 5,  32'hDEADBEEF, 0,            32'h000000D3,  0,    0, 0);
        row(0, 0, 1, 1, 5,  32'h1234,     0, 0,            0,   0,     5, 4,  0,            32'hDEADBEEF, 32'h000000D3,  0,    0, 0);
        row(0, 0, 0, 0, 0,  0,            0, 0,            0,   0,     5, 4,  0,            32'hDEADBEEF, 32'h000000D3,  0,    0, 0);
        row(0, 0, 0, 0, 0,  0,            0, 0,            0,   0,     5, 4,  0,            32'hDEADBEEF, 32'h000000D3,  0,    0, 0);
        row(0, 0, 0, 1, 15, 32'h1000,     0, 0,            0,   32'h200, 15, 4, 32'h208,    32'hDEADBEEF, 32'h000000D3,  0,    0, 0);
        row(0, 0, 0, 0, 0,  0,            0, 0,            0,   32'h200, 15, 4, 32'h208,    32'hDEADBEEF, 32'h000000D3,  0,    1, 32'h1000);
        row(0, 0, 0, 0, 0,  0,            0, 0,            0,   0,     15, 0, 32'h8,        0,            32'h000000D3,  0,    0, 0);
        row(0, 0, 0, 1, 2,  9,            0, 0,            0,   0,     2, 6,  9,            0,            32'h000000D3,  0,    0, 0);
        row(0, 1, 0, 1, 6,  7,            0, 0,            0,   0,     6, 2,  7,            9,            32'h000000D3,  0,    0, 0);
        row(0, 1, 0, 1, 6,  7,            0, 0,            0,   0,     6, 2,  7,            9,            32'h000000D3,  0,    0, 0);
        row(0, 1, 0, 1, 6,  7,            0, 0,            0,   0,     6, 2,  7,            9,            32'h000000D3,  0,    0, 0);
        row(0, 0, 1, 1, 6,  7,            0, 0,            0,   0,     6, 2,  0,            9,            32'h000000D3,  0,    0, 0);
        row(0, 0, 0, 1, 6,  7,            0, 0,            0,   0,     6, 2,  7,            9,            32'h000000D3,  0,    0, 0);
        row(0, 0, 0, 0, 0,  0,            0, 0,            0,   0,     6, 2,  7,            9,            32'h000000D3,  0,    0, 0);
        row(0, 0, 0, 0, 0,  0,            0, 0,            0,   0,     6, 2,  7,            9,            32'h000000D3,  0,    0, 0);
        row(0, 0, 0, 1, 15, 32'h2000,     0, 0,            0,   0,     6, 2,  7,            9,            32'h000000D3,  0,    0, 0);
        row(0, 1, 0, 0, 0,  0,            0, 0,            0,   0,     6, 2,  7,            9,            32'h000000D3,  0,    1, 32'h2000);
        row(0, 1, 0, 0, 0,  0,            0, 0,            0,   0,     6, 2,  7,            9,            32'h000000D3,  0,    0, 0);
        row(0, 0, 0, 0, 0,  0,            0, 0,            0,   0,     6, 2,  7,            9,            32'h000000D3,  0,    0, 0);
        row(0, 0, 0, 0, 0,  0,            1, 32'h600000D3, 32'h10, 0,  4, 2,  32'hDEADBEEF, 9,            32'h600000D3,  32'h10, 0, 0);
        row(1, 0, 0, 0, 0,  0,            0, 0,            0,   0,     4, 2,  32'hDEADBEEF, 9,            32'h600000D3,  32'h10, 0, 0);
        row(0, 0, 0, 0, 0,  0,            0, 0,            0,   0,     4, 2,  0,            0,            32'h000000D3,  0,    0, 0);
        row(0, 0, 0, 1, 3,  32'h11,       0, 0,            0,   0,     3, 3,  32'h11,       32'h11,       32'h000000D3,  0,    0, 0);
        row(0, 0, 0, 1, 3,  32'h22,       0, 0,            0,   0,     3, 0,  32'h22,       0,            32'h000000D3,  0,    0, 0);
        row(0, 0, 0, 0, 0,  0,            0, 0,            0,   0,     3, 0,  32'h22,       0,            32'h000000D3,  0,    0, 0);
        row(0, 0, 0, 0, 0,  0,            0, 0,            0,   0,     3, 0,  32'h22,       0,            32'h000000D3,  0,    0, 0);

        foreach (vecs[i]) begin
            drive(vecs[i].rst, vecs[i].stall, vecs[i].bub, vecs[i].wr, vecs[i].num, vecs[i].data,
                  vecs[i].cu, vecs[i].cpsr_in, vecs[i].spsr_in, vecs[i].pc,
                  vecs[i].n0, vecs[i].n1, 4'd0);
            #1;
            chk($sformatf("row%0d rd0", i), bus.rd_data0_1a, vecs[i].e0);
            chk($sformatf("row%0d rd1", i), bus.rd_data1_1a, vecs[i].e1);
            chk($sformatf("row%0d cpsr", i), bus.cpsr, vecs[i].ecpsr);
            chk($sformatf("row%0d spsr", i), bus.spsr, vecs[i].espsr);
            chk($sformatf("row%0d jmp", i), {31'd0, bus.jmp_4a}, {31'd0, vecs[i].ejmp});
            if (vecs[i].ejmp) chk($sformatf("row%0d jmppc", i), bus.jmppc_4a, vecs[i].ejpc);
            $display("row %0d rd0=%h rd1=%h cpsr=%h jmp=%b jmppc=%h", i,
                     bus.rd_data0_1a, bus.rd_data1_1a, bus.cpsr, bus.jmp_4a, bus.jmppc_4a);
            @(posedge clk); #1;
        end

        // random traffic against the architectural model
        drive(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        @(posedge clk); #1;
        model_reset();
        for (int c = 0; c < 400; c++) begin
            drive(($urandom_range(0, 49) == 0),
                  ($urandom_range(0, 3) == 0),
                  ($urandom_range(0, 3) == 0),
                  ($urandom_range(0, 9) < 6),
                  4'($urandom_range(0, 15)),
                  $urandom,
                  ($urandom_range(0, 4) == 0),
                  $urandom, $urandom, $urandom,
                  4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)));
            #1;
            chk($sformatf("rnd%0d rd0", c), bus.rd_data0_1a, m_read(bus.rd_num0_1a));
            chk($sformatf("rnd%0d rd1", c), bus.rd_data1_1a, m_read(bus.rd_num1_1a));
            chk($sformatf("rnd%0d rd2", c), bus.rd_data2_1a, m_read(bus.rd_num2_1a));
            chk($sformatf("rnd%0d cpsr", c), bus.cpsr,
                (!bus.bubble_3a && bus.cpsrup_3a) ? bus.cpsr_3a : m_cpsr);
            chk($sformatf("rnd%0d spsr", c), bus.spsr,
                (!bus.bubble_3a && bus.cpsrup_3a) ? bus.spsr_3a : m_spsr);
            chk($sformatf("rnd%0d jmp", c), {31'd0, bus.jmp_4a}, {31'd0, m_jmp});
            if (m_jmp) chk($sformatf("rnd%0d jmppc", c), bus.jmppc_4a, m_jpc);
            $display("rnd %0d rst=%b st=%b bub=%b wr=%b r%0d=%h rd0=%h jmp=%b", c, rst,
                     bus.stall_3a, bus.bubble_3a, bus.write_reg_3a, bus.write_num_3a,
                     bus.write_data_3a, bus.rd_data0_1a, bus.jmp_4a);
            // advance the model by what this clock edge accepts
            if (rst) begin
                model_reset();
            end else if (bus.stall_3a || bus.bubble_3a) begin
                m_jmp = 1'b0;
            end else begin
                m_jmp = bus.write_reg_3a && (bus.write_num_3a == 4'd15);
                m_jpc = bus.write_data_3a;
                if (bus.write_reg_3a && bus.write_num_3a != 4'd15)
                    m_regs[bus.write_num_3a] = bus.write_data_3a;
                if (bus.cpsrup_3a) begin
                    m_cpsr = bus.cpsr_3a;
                    m_spsr = bus.spsr_3a;
                end
            end
            @(posedge clk); #1;
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
